// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op encodings and FSM states for the Hi/Lo mul/div unit
package hilo_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_MTHI  = 4'd0,
        OP_MTLO  = 4'd1,
        OP_MULT  = 4'd2,
        OP_MULTU = 4'd3,
        OP_DIV   = 4'd4,
        OP_DIVU  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/hilo_seq_divider.sv
// rtl/hilo_seq_divider.sv - restoring radix-2 unsigned divider, result valid WIDTH cycles after start
module hilo_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             valid_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d, valid_q, valid_d;
    logic [WIDTH:0]   trial;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        valid_d = valid_q;
        // Top bit set means the shifted remainder was smaller than the divisor.
        trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (start_i) begin
            rem_d   = '0;
            quo_d   = dividend_i;
            dvs_d   = divisor_i;
            cnt_d   = '0;
            run_d   = 1'b1;
            valid_d = 1'b0;
        end else if (run_q) begin
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                run_d   = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            valid_q <= valid_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign valid_o     = valid_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - Hi/Lo registers with iterative signed/unsigned multiply/divide engine
// Define HILO_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
import hilo_pkg::*;

module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic [WIDTH-1:0] hi_read_data_o,
    output logic [WIDTH-1:0] lo_read_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d, rem_neg_q, rem_neg_d;
    logic               done_q, done_d, dbz_q, dbz_d;

    logic               start_ok, is_signed, is_div, a_neg, b_neg, div_start, div_valid;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_mag, rem_mag;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] prod_fix;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
`ifdef HILO_MADD_EN
        return op <= OP_MSUBU;
`else
        return op <= OP_DIVU;
`endif
    endfunction

    assign start_ok  = start_i && (state_q == IDLE) && op_legal(op_i);
    assign is_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign is_signed = (op_i == OP_MULT) || (op_i == OP_DIV) || (op_i == OP_MADD) || (op_i == OP_MSUB);
    assign a_neg     = is_signed && operand_a_i[WIDTH-1];
    assign b_neg     = is_signed && operand_b_i[WIDTH-1];
    assign a_mag     = a_neg ? -operand_a_i : operand_a_i;
    assign b_mag     = b_neg ? -operand_b_i : operand_b_i;
    assign div_start = start_ok && is_div && (operand_b_i != '0);

    hilo_seq_divider #(.WIDTH(WIDTH)) u_divider (
        .clk_i       (clk_i),
        .rst_i       (reset_i),
        .start_i     (div_start),
        .dividend_i  (a_mag),
        .divisor_i   (b_mag),
        .quotient_o  (quo_mag),
        .remainder_o (rem_mag),
        .valid_o     (div_valid)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        // Shift-add step: conditionally add multiplicand to the upper half, then shift right.
        add_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_fix  = neg_q ? -prod_q : prod_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    op_d      = op_i;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    cnt_d     = '0;
                    mcand_d   = a_mag;
                    prod_d    = {{WIDTH{1'b0}}, b_mag};
                    if (op_i == OP_MTHI) begin
                        hi_d   = operand_a_i;
                        done_d = 1'b1;
                    end else if (op_i == OP_MTLO) begin
                        lo_d   = operand_a_i;
                        done_d = 1'b1;
                    end else if (is_div) begin
                        if (operand_b_i == '0) begin
                            done_d = 1'b1;
                            dbz_d  = 1'b1;
                        end else begin
                            state_d = DIV;
                        end
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                prod_d = {add_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            DIV: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
                    if (div_valid) begin
                        lo_d = neg_q ? -quo_mag : quo_mag;
                        hi_d = rem_neg_q ? -rem_mag : rem_mag;
                    end
`ifdef HILO_MADD_EN
                end else if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
                    {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
                end else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) begin
                    {hi_d, lo_d} = {hi_q, lo_q} - prod_fix;
`endif
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign hi_read_data_o = hi_q;
    assign lo_read_data_o = lo_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign div_by_zero_o  = dbz_q;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Parametrised successor to the plain Hi/Lo register pair. Holds the Hi and Lo architectural registers and adds an iterative multiply/divide engine that writes them: signed/unsigned multiply and divide, plus direct moves to Hi and Lo. Sits beside the ALU in the execute stage. Busy stalls the pipeline; Done marks the cycle when new Hi/Lo values become visible.

Parameters:
WIDTH, 32, operand and Hi/Lo register width; must be even and at least 8.

Ports:
Clk  in  1  clock, all state updates on the rising edge
Reset  in  1  asynchronous, active-high; clears all state
Start  in  1  operation request; sampled only while idle
Op  in  4  operation code (see package)
OperandA  in  WIDTH  rs operand / dividend / move source
OperandB  in  WIDTH  rt operand / divisor
HiReadData  out  WIDTH  current Hi
LoReadData  out  WIDTH  current Lo
Busy  out  1  engine iterating; the pipeline must stall
Done  out  1  one-cycle pulse: the operation has completed
DivByZero  out  1  one-cycle pulse coincident with Done for a divide by zero

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, FSM=IDLE. Reset asserted mid-operation aborts it: no Done, and Hi/Lo are cleared.
- FSM states: IDLE, MUL, DIV, FIX. Busy=1 in MUL, DIV and FIX only.
- Start is accepted only in IDLE. Start while Busy is ignored (no queue). An illegal Op is ignored: no Done, no state change.
- Cycle numbering: cycle 0 is the cycle in which Start is sampled high.
- MTHI/MTLO: Hi (or Lo) := OperandA at the end of cycle 0. Done=1 in cycle 1. Busy never asserts.
- MULT/MULTU/DIV/DIVU:
  - Operands are latched in cycle 0.
  - Cycles 1..WIDTH: one radix-2 iteration per cycle (shift-add for multiply, restoring for divide), in state MUL or DIV.
  - Cycle WIDTH+1: state FIX applies the sign correction, and Hi/Lo are written at the end of that cycle.
  - Cycle WIDTH+2: Done=1, Busy=0, new Hi/Lo visible, FSM in IDLE. A new Start in this cycle is accepted (back-to-back operation).
- Atomic update: Hi/Lo hold their old values for the whole operation; both are written on the same edge.
- Signed arithmetic: the engine operates on magnitudes. The product is negated if the operand signs differ.
- Multiply result: {Hi,Lo} = full 2*WIDTH product.
- Divide result: Lo = quotient, truncated toward zero. Hi = remainder, taking the sign of the dividend.
- Divide overflow: most-negative / -1 gives Lo = most-negative and Hi = 0.
- Divide by zero: no iteration. Done=1 and DivByZero=1 in cycle 1. Hi/Lo are unchanged and Busy never asserts.
- Operand inputs may change after cycle 0 without affecting the result.

Optional Feature:
HILO_MADD_EN:
- Defined: adds MADD, MADDU, MSUB and MSUBU. The FSM path and latency are the same as MULT.
  - In FIX, {Hi,Lo} := {Hi,Lo} + product (MADD/MADDU) or {Hi,Lo} - product (MSUB/MSUBU).
  - The sum wraps modulo 2^(2*WIDTH).
  - The accumulator value used is the Hi/Lo content at FIX.
- Not defined: codes 6-9 are illegal and ignored, and the 2*WIDTH adder/subtractor is absent.

Decomposition:
- Package hilo_pkg:
  - Op encodings: MTHI=0, MTLO=1, MULT=2, MULTU=3, DIV=4, DIVU=5, MADD=6, MADDU=7, MSUB=8, MSUBU=9; all others illegal.
  - FSM state enum (IDLE, MUL, DIV, FIX).
  - Op width constant (4).
- One sub-module, hilo_seq_divider: restoring iterative unsigned divider core.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, valid after WIDTH cycles.
- The multiply iteration and the FSM stay in the top level.

Test Plan (WIDTH=32):
1. Reset, then MTHI 0x7f00, then MTLO 0x00ff -> Hi=0x7f00, Lo=0x00ff; Done pulses in cycle 1 of each; Busy stays 0.
2. MULT 0xFFFFFFFD * 7 -> Done at cycle 34 with Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. MULTU 0xFFFFFFFF * 2 -> Hi=0x1, Lo=0xFFFFFFFE.
3. DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100 / 7 -> Lo=14, Hi=2. DIV 0x80000000 / -1 -> Lo=0x80000000, Hi=0.
4. DIVU 5 / 0 with Hi=0x7f00 beforehand -> Done and DivByZero both high in cycle 1; Hi/Lo unchanged; Busy=0 throughout.
5. Start DIVU at cycle 5 while a MULT is Busy -> ignored, only the MULT result appears. Separately, Reset asserted at cycle 10 of a MULT -> Hi=Lo=0, Busy=0, no Done.
6. With HILO_MADD_EN: Hi=0, Lo=10, then MADD 3*4 -> Lo=22. Then MSUB 5*5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFD. Without the macro, Op=6 -> no Done, Hi/Lo unchanged.
